// File: rtl/oka_205bit_seq.sv
// oka_205bit_seq: time-multiplexed 205-bit GF(2)[x] multiplier.
// One 103-bit carry-less core is reused for the three even/odd Karatsuba sub-products
// P0=A0*B0, P1=A1*B1 and P2=(A0^A1)*(B0^B1), which are then recombined into the 409-bit product.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a,b valid          in_ready   operands can be accepted this cycle
//   a, b       N-bit operands (bit i = coeff of x^i)
//   out_valid  y holds a completed product out_ready  downstream accepts y
//   y          registered 2N-1 bit product
//   busy       high in any state other than idle
//   op_count   wrapping count of out_valid && out_ready handshakes
//
// Optional build macro OKA_SEQ_CORE_REG_EN: registers the core output, so every MUL state takes
// two cycles (issue, capture) and the latency becomes 6 cycles.
module oka_205bit_seq #(
  parameter int unsigned N     = 205,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-2:0]     y,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam int unsigned H  = (N + 1) / 2;
  localparam int unsigned PW = 2 * H - 1;
  localparam int unsigned YW = 2 * N - 1;

  typedef enum logic [2:0] {StIdle, StMul0, StMul1, StMul2, StDone} state_e;

  state_e            r_state, w_next;
  logic [H-1:0]      r_a0, r_a1, r_b0, r_b1;
  logic [H-1:0]      w_a0, w_a1, w_b0, w_b1;
  logic [H-1:0]      w_ca, w_cb;
  logic [PW-1:0]     r_p0, r_p1;
  logic [PW-1:0]     w_core, w_pk;
  logic [YW-1:0]     r_y, w_y;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_acc, w_adv, w_hs;

  // Carry-less H x H multiply: the shared core.
  function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] z);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++) begin
      if (z[i]) acc = acc ^ (PW'(x) << i);
    end
    return acc;
  endfunction

  // Place coefficient i at bit 2i, i.e. P(x) -> P(x^2).
  function automatic logic [YW-1:0] spread(input logic [PW-1:0] p);
    logic [YW-1:0] s;
    s = '0;
    for (int i = 0; i < PW; i++) s[2*i] = p[i];
    return s;
  endfunction

  // Even/odd coefficient split; the odd half is one coefficient short, top bit stays 0.
  always_comb begin
    w_a0 = '0;
    w_a1 = '0;
    w_b0 = '0;
    w_b1 = '0;
    for (int j = 0; j < H; j++) begin
      w_a0[j] = a[2*j];
      w_b0[j] = b[2*j];
    end
    for (int j = 0; j < H - 1; j++) begin
      w_a1[j] = a[2*j+1];
      w_b1[j] = b[2*j+1];
    end
  end

  assign in_ready = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_hs     = (r_state == StDone) && out_ready;

  // Core operand mux, driven only from registered operands.
  always_comb begin
    w_ca = r_a0;
    w_cb = r_b0;
    unique case (r_state)
      StMul1: begin
        w_ca = r_a1;
        w_cb = r_b1;
      end
      StMul2: begin
        w_ca = r_a0 ^ r_a1;
        w_cb = r_b0 ^ r_b1;
      end
      default: ;
    endcase
  end

  assign w_core = clmul_h(w_ca, w_cb);

`ifdef OKA_SEQ_CORE_REG_EN
  logic          r_phase;
  logic [PW-1:0] r_pc;

  // Phase 0 issues operands to the core, phase 1 consumes the registered core result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 1'b0;
      r_pc    <= '0;
    end else begin
      r_pc <= w_core;
      if (r_state inside {StMul0, StMul1, StMul2}) r_phase <= ~r_phase;
      else                                         r_phase <= 1'b0;
    end
  end

  assign w_adv = r_phase;
  assign w_pk  = r_pc;
`else
  assign w_adv = 1'b1;
  assign w_pk  = w_core;
`endif

  // a*b = P0(x^2) + x*(P0^P1^P2)(x^2) + x^2*P1(x^2)
  assign w_y = spread(r_p0) ^ (spread(r_p0 ^ r_p1 ^ w_pk) << 1) ^ (spread(r_p1) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle: if (w_acc) w_next = StMul0;
      StMul0: if (w_adv) w_next = StMul1;
      StMul1: if (w_adv) w_next = StMul2;
      StMul2: if (w_adv) w_next = StDone;
      StDone: begin
        if (w_acc)          w_next = StMul0;
        else if (out_ready) w_next = StIdle;
      end
      default: w_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a0  <= '0;
      r_a1  <= '0;
      r_b0  <= '0;
      r_b1  <= '0;
      r_p0  <= '0;
      r_p1  <= '0;
      r_y   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_a0 <= w_a0;
        r_a1 <= w_a1;
        r_b0 <= w_b0;
        r_b1 <= w_b1;
      end
      if ((r_state == StMul0) && w_adv) r_p0 <= w_pk;
      if ((r_state == StMul1) && w_adv) r_p1 <= w_pk;
      if ((r_state == StMul2) && w_adv) r_y  <= w_y;
      if (w_hs) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign y         = r_y;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_oka_205bit_seq.sv
// Self-checking bench for oka_205bit_seq: directed corner cases plus randomized operands with
// random back-pressure, checked against a plain shift-and-xor carry-less multiply.
module tb_oka_205bit_seq;

  localparam int N     = 205;
  localparam int YW    = 2 * N - 1;
  localparam int CNT_W = 16;
`ifdef OKA_SEQ_CORE_REG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [YW-1:0]    y;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  oka_205bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [YW-1:0] clmul_ref(input logic [N-1:0] x, input logic [N-1:0] z);
    logic [YW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (z[i]) r = r ^ (YW'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [223:0] w;
    for (int k = 0; k < 7; k++) w[k*32 +: 32] = $urandom();
    unique case ($urandom_range(0, 15))
      0:       return '1;
      1:       return '0;
      default: return w[N-1:0];
    endcase
  endfunction

  // Bounded wait for out_valid, counting clock edges since the accept edge.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Called #1 after a clock edge with the DUT able to accept.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = rnd_op();
    b        = rnd_op();
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb);
    int cyc;
    issue(ta, tb);
    wait_valid(cyc);
    check_eq({tag, "_lat"}, YW'(cyc), YW'(LAT));
    check_eq({tag, "_y"}, y, clmul_ref(ta, tb));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    check_eq({tag, "_cnt"}, YW'(op_count), YW'(exp_cnt));
    check_eq({tag, "_ovld_clr"}, YW'(out_valid), YW'(1'b0));
  endtask

  initial begin
    logic [N-1:0]  ta, tb, ra, rb, ca, cb;
    logic [YW-1:0] e, y_hold;
    int            cyc;
    bit            pend, hs, o;
    int            guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    exp_cnt   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_in_ready", YW'(in_ready), YW'(1'b1));
    check_eq("rst_out_valid", YW'(out_valid), YW'(1'b0));
    check_eq("rst_y", y, '0);
    check_eq("rst_busy", YW'(busy), YW'(1'b0));
    check_eq("rst_cnt", YW'(op_count), YW'(0));

    // Basic products against hand-computed constants.
    out_ready = 1'b1;
    run_op("one", N'(1), N'(1));
    check_eq("one_const", y, YW'(1));
    retire("one");

    run_op("seven", N'(7), N'(7));
    check_eq("seven_const", y, YW'(16'h15));
    retire("seven");

    run_op("three_five", N'(3), N'(5));
    check_eq("three_five_const", y, YW'(16'hF));
    retire("three_five");

    ta = '0; ta[204] = 1'b1;
    e  = '0; e[408]  = 1'b1;
    run_op("top_sq", ta, ta);
    check_eq("top_sq_const", y, e);
    retire("top_sq");

    tb = '0; tb[203] = 1'b1;
    e  = '0; e[407]  = 1'b1;
    run_op("top_odd", tb, ta);
    check_eq("top_odd_const", y, e);
    retire("top_odd");

    // Back-pressure: result must hold, then a back-to-back accept on the release cycle.
    out_ready = 1'b0;
    ta = rnd_op();
    tb = rnd_op();
    run_op("bp", ta, tb);
    y_hold = y;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_y_hold", y, y_hold);
      check_eq("bp_ovld_hold", YW'(out_valid), YW'(1'b1));
      check_eq("bp_in_ready", YW'(in_ready), YW'(1'b0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = N'(3);
    b         = N'(5);
    #1;
    check_eq("b2b_in_ready", YW'(in_ready), YW'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_cnt++;
    check_eq("b2b_cnt", YW'(op_count), YW'(exp_cnt));
    check_eq("b2b_busy", YW'(busy), YW'(1'b1));
    check_eq("b2b_ovld", YW'(out_valid), YW'(1'b0));
    wait_valid(cyc);
    check_eq("b2b_lat", YW'(cyc), YW'(LAT));
    check_eq("b2b_y", y, YW'(16'hF));
    retire("b2b");

    // Reset in the middle of the second multiply step.
    issue(rnd_op(), rnd_op());
    repeat (LAT / 3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ovld", YW'(out_valid), YW'(1'b0));
    check_eq("mid_rst_y", y, '0);
    check_eq("mid_rst_busy", YW'(busy), YW'(1'b0));
    check_eq("mid_rst_cnt", YW'(op_count), YW'(0));
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = '0;
    run_op("post_rst", N'(5), N'(3));
    check_eq("post_rst_const", y, YW'(16'hF));
    retire("post_rst");

    // Randomized operands with random back-pressure and opportunistic back-to-back issue.
    pend = 1'b0;
    ra   = rnd_op();
    rb   = rnd_op();
    for (int k = 0; k < 1000; k++) begin
      if (!pend) begin
        out_ready = 1'($urandom_range(0, 1));
        issue(ra, rb);
      end
      ca = ra;
      cb = rb;
      ra = rnd_op();
      rb = rnd_op();
      wait_valid(cyc);
      check_eq("rnd_lat", YW'(cyc), YW'(LAT));
      check_eq("rnd_y", y, clmul_ref(ca, cb));
      hs    = 1'b0;
      pend  = 1'b0;
      guard = 0;
      while (!hs && guard < 64) begin
        o         = ($urandom_range(0, 3) != 0);
        out_ready = o;
        if (o && k < 999 && $urandom_range(0, 1) == 1) begin
          in_valid = 1'b1;
          a        = ra;
          b        = rb;
          pend     = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard++;
        if (o) begin
          hs = 1'b1;
          exp_cnt++;
        end
      end
      check_eq("rnd_cnt", YW'(op_count), YW'(exp_cnt));
    end
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
